// File: rtl/game_sequencer.sv
// Game controller for the flappy-bird datapath: button synchroniser and
// debouncer, IDLE/PLAY/DYING/OVER state machine, flap pulses, score and
// high-score keeping. Every output comes straight from a flop.
module game_sequencer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DEATH_FRAMES    = 60,
    parameter int OVER_HOLD       = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_raw,
    input  logic        frame_tick,
    input  logic        collision,
    input  logic        pass_flag,
    output logic        world_reset,
    output logic        world_enable,
    output logic        flap,
    output logic [1:0]  state,
    output logic [15:0] score,
    output logic [15:0] high_score,
    output logic        new_high
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_DYING = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    logic            r_sync1, r_sync2;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_db_level, r_db_level_d;
    logic            r_pass_prev;
    state_t          r_state;
    logic [7:0]      r_frame_cnt;
    logic [15:0]     r_score, r_high;
    logic            r_new_high, r_flap, r_world_reset, r_world_enable;

    logic            w_press, w_pass_edge;
    logic [7:0]      w_frame_inc;
    state_t          w_state_next;
    logic [7:0]      w_frame_cnt_next;
    logic [15:0]     w_score_next, w_high_next;
    logic            w_new_high_next, w_flap_next;

    // Press is the first cycle the debounced level is seen high.
    assign w_press     = r_db_level & ~r_db_level_d;
    assign w_pass_edge = pass_flag & ~r_pass_prev;
    assign w_frame_inc = r_frame_cnt + 8'd1;

    // Two-flop synchroniser followed by a stability counter on the button.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_db_cnt     <= '0;
            r_db_level   <= 1'b0;
            r_db_level_d <= 1'b0;
        end else begin
            r_sync1      <= btn_raw;
            r_sync2      <= r_sync1;
            r_db_level_d <= r_db_level;
            if (r_sync2 == r_db_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                r_db_level <= ~r_db_level;
                r_db_cnt   <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    // Previous pass_flag sample for edge detection; tracks in every state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_pass_prev <= 1'b0;
        else       r_pass_prev <= pass_flag;
    end

    // Next-state, counter, score and flap decisions.
    always_comb begin
        w_state_next     = r_state;
        w_frame_cnt_next = r_frame_cnt;
        w_score_next     = r_score;
        w_high_next      = r_high;
        w_new_high_next  = r_new_high;
        w_flap_next      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_press) begin
                    w_state_next    = S_PLAY;
                    w_flap_next     = 1'b1;
                    w_score_next    = 16'd0;
                    w_new_high_next = 1'b0;
                end
            end
            S_PLAY: begin
                // Collision overrides both a flap and a pass in the same cycle.
                if (collision) begin
                    w_state_next     = S_DYING;
                    w_frame_cnt_next = 8'd0;
                end else begin
                    w_flap_next = w_press;
                    if (w_pass_edge && (r_score != 16'hFFFF))
                        w_score_next = r_score + 16'd1;
                end
            end
            S_DYING: begin
                if (frame_tick) begin
                    if (w_frame_inc == 8'(DEATH_FRAMES)) begin
                        w_state_next     = S_OVER;
                        w_frame_cnt_next = 8'd0;
                        if (r_score > r_high) begin
                            w_high_next     = r_score;
                            w_new_high_next = 1'b1;
                        end
                    end else begin
                        w_frame_cnt_next = w_frame_inc;
                    end
                end
            end
            default: begin // S_OVER
                if (w_press && (r_frame_cnt == 8'(OVER_HOLD))) begin
                    w_state_next = S_IDLE;
                end else if (frame_tick && (r_frame_cnt != 8'(OVER_HOLD))) begin
                    w_frame_cnt_next = w_frame_inc;
                end
            end
        endcase
    end

    // State register plus all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_frame_cnt    <= 8'd0;
            r_score        <= 16'd0;
            r_high         <= 16'd0;
            r_new_high     <= 1'b0;
            r_flap         <= 1'b0;
            r_world_reset  <= 1'b1;
            r_world_enable <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_frame_cnt    <= w_frame_cnt_next;
            r_score        <= w_score_next;
            r_high         <= w_high_next;
            r_new_high     <= w_new_high_next;
            r_flap         <= w_flap_next;
            r_world_reset  <= (w_state_next == S_IDLE);
            r_world_enable <= (w_state_next == S_PLAY);
        end
    end

    assign state        = r_state;
    assign score        = r_score;
    assign high_score   = r_high;
    assign new_high     = r_new_high;
    assign flap         = r_flap;
    assign world_reset  = r_world_reset;
    assign world_enable = r_world_enable;

endmodule
